// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM power-up init sequencer:
// command encodings, FSM states and mode-register fields.
package sdram_pkg;

   localparam logic [3:0] CMD_INHIBIT = 4'b1111;
   localparam logic [3:0] CMD_NOP     = 4'b0111;
   localparam logic [3:0] CMD_PRE     = 4'b0010;
   localparam logic [3:0] CMD_REF     = 4'b0001;
   localparam logic [3:0] CMD_LMR     = 4'b0000;

   // Mode register fields: CAS latency, burst type, burst length
   localparam logic [2:0] MR_CL = 3'd3;
   localparam logic       MR_BT = 1'b0;
   localparam logic [2:0] MR_BL = 3'b010;

   localparam logic [12:0] MODE_DEFAULT =
      {6'b000000, MR_CL, MR_BT, MR_BL};

   localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_PRE,
      ST_TRP,
      ST_REF,
      ST_TRFC,
      ST_LMR,
      ST_TMRD,
      ST_DONE
   } init_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable gap down-counter for the SDRAM init sequencer.
// Holds at zero; zero flag is combinational from the count.
module sdram_init_timer
   import sdram_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             s_clk,
   input  logic             s_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up init sequencer: WAIT, PRECHARGE ALL, N x REFRESH, LMR.
// Optional SDRAM_INIT_REINIT_EN adds i_reinit to rerun from PRECHARGE.
module sdram_init_ctrl
   import sdram_pkg::*;
#(
   parameter int          P_WAIT_CYCLES = 20000,
   parameter int          P_TRP         = 2,
   parameter int          P_TRFC        = 7,
   parameter int          P_TMRD        = 2,
   parameter int          P_REFRESH_NUM = 8,
   parameter logic [12:0] P_MODE_REG    = MODE_DEFAULT
) (
   input  logic        s_clk,
   input  logic        s_rst,
`ifdef SDRAM_INIT_REINIT_EN
   input  logic        i_reinit,
`endif
   output logic        o_cke,
   output logic [3:0]  o_cmd,
   output logic [12:0] o_addr,
   output logic [1:0]  o_ba,
   output logic        o_init_done
);

   localparam int TW =
      $clog2(max_of(max_of(P_WAIT_CYCLES, P_TRP),
                    max_of(P_TRFC, P_TMRD))) + 1;

   localparam logic [TW-1:0] LD_WAIT = TW'(P_WAIT_CYCLES - 1);
   localparam logic [TW-1:0] LD_TRP  = TW'(P_TRP - 1);
   localparam logic [TW-1:0] LD_TRFC = TW'(P_TRFC - 1);
   localparam logic [TW-1:0] LD_TMRD = TW'(P_TMRD - 1);
   localparam logic [3:0]    REF_N   = 4'(P_REFRESH_NUM);

   init_state_t   state;
   init_state_t   nxt;
   logic [3:0]    ref_cnt;
   logic          more;
   logic          t_load;
   logic [TW-1:0] t_val;
   logic          t_zero;
   logic [3:0]    cmd_d;
   logic [12:0]  addr_d;
   logic [1:0]    ba_d;
   logic          done_d;
   logic          go_again;

`ifdef SDRAM_INIT_REINIT_EN
   logic reinit_q;

   // One-cycle sample so PRECHARGE lands one edge after the request
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         reinit_q <= 1'b0;
      end else begin
         reinit_q <= (state == ST_DONE) && i_reinit;
      end
   end

   assign go_again = reinit_q;
`else
   assign go_again = 1'b0;
`endif

   sdram_init_timer #(
      .WIDTH (TW)
   ) u_timer (
      .s_clk    (s_clk),
      .s_rst    (s_rst),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   assign more = (ref_cnt < REF_N);

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         state <= ST_WAIT;
      end else begin
         state <= nxt;
      end
   end

   // Command states last one cycle; a zero timer skips the gap state
   always_comb begin
      nxt = state;
      unique case (state)
         ST_WAIT: if (o_cke && t_zero) nxt = ST_PRE;
         ST_PRE:  nxt = t_zero ? ST_REF : ST_TRP;
         ST_TRP:  if (t_zero) nxt = ST_REF;
         ST_REF: begin
            if (!t_zero)   nxt = ST_TRFC;
            else if (more) nxt = ST_REF;
            else           nxt = ST_LMR;
         end
         ST_TRFC: if (t_zero) nxt = more ? ST_REF : ST_LMR;
         ST_LMR:  nxt = t_zero ? ST_DONE : ST_TMRD;
         ST_TMRD: if (t_zero) nxt = ST_DONE;
         ST_DONE: if (go_again) nxt = ST_PRE;
         default: nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      t_load = 1'b0;
      t_val  = '0;
      if (state == ST_WAIT && !o_cke) begin
         t_load = 1'b1;
         t_val  = LD_WAIT;
      end else begin
         unique case (1'b1)
            (nxt == ST_PRE): begin
               t_load = 1'b1;
               t_val  = LD_TRP;
            end
            (nxt == ST_REF): begin
               t_load = 1'b1;
               t_val  = LD_TRFC;
            end
            (nxt == ST_LMR): begin
               t_load = 1'b1;
               t_val  = LD_TMRD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         ref_cnt <= 4'd0;
      end else if (nxt == ST_PRE) begin
         ref_cnt <= 4'd0;
      end else if (nxt == ST_REF) begin
         ref_cnt <= ref_cnt + 4'd1;
      end
   end

   always_comb begin
      cmd_d  = CMD_NOP;
      addr_d = '0;
      ba_d   = '0;
      done_d = 1'b0;
      unique case (1'b1)
         (nxt == ST_PRE): begin
            cmd_d  = CMD_PRE;
            addr_d = ADDR_ALL_BANKS;
         end
         (nxt == ST_REF): cmd_d = CMD_REF;
         (nxt == ST_LMR): begin
            cmd_d  = CMD_LMR;
            addr_d = P_MODE_REG;
         end
         (nxt == ST_DONE): done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         o_cke       <= 1'b0;
         o_cmd       <= CMD_INHIBIT;
         o_addr      <= '0;
         o_ba        <= '0;
         o_init_done <= 1'b0;
      end else begin
         o_cke       <= 1'b1;
         o_cmd       <= cmd_d;
         o_addr      <= addr_d;
         o_ba        <= ba_d;
         o_init_done <= done_d;
      end
   end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Randomized self-checking bench for sdram_init_ctrl.
// Covers defaults, a short-gap override and (with macro) reinit.
module tb_sdram_init_ctrl;

   localparam int W0 = 20000, TRP0 = 2, TRFC0 = 7;
   localparam int TMRD0 = 2, N0 = 8;
   localparam int W1 = 4, TRP1 = 1, TRFC1 = 1;
   localparam int TMRD1 = 1, N1 = 1;
   localparam logic [12:0] MODE = 13'h032;

   localparam int D0 = W0 + 1 + TRP0 + N0 * TRFC0 + TMRD0;
   localparam int D1 = W1 + 1 + TRP1 + N1 * TRFC1 + TMRD1;
   localparam int R0 = 1 + TRP0 + N0 * TRFC0 + TMRD0;
   localparam int R1 = 1 + TRP1 + N1 * TRFC1 + TMRD1;

   logic clk;
   logic rst0, rst1;
   logic reinit0, reinit1;
   logic        cke0, cke1;
   logic [3:0]  cmd0, cmd1;
   logic [12:0] addr0, addr1;
   logic [1:0]  ba0, ba1;
   logic        done0, done1;

   int n_chk = 0;
   int n_fail = 0;

   sdram_init_ctrl u_dut0 (
      .s_clk       (clk),
      .s_rst       (rst0),
`ifdef SDRAM_INIT_REINIT_EN
      .i_reinit    (reinit0),
`endif
      .o_cke       (cke0),
      .o_cmd       (cmd0),
      .o_addr      (addr0),
      .o_ba        (ba0),
      .o_init_done (done0)
   );

   sdram_init_ctrl #(
      .P_WAIT_CYCLES (W1),
      .P_TRP         (TRP1),
      .P_TRFC        (TRFC1),
      .P_TMRD        (TMRD1),
      .P_REFRESH_NUM (N1)
   ) u_dut1 (
      .s_clk       (clk),
      .s_rst       (rst1),
`ifdef SDRAM_INIT_REINIT_EN
      .i_reinit    (reinit1),
`endif
      .o_cke       (cke1),
      .o_cmd       (cmd1),
      .o_addr      (addr1),
      .o_ba        (ba1),
      .o_init_done (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected {cke,done,ba,addr,cmd} at edge k, PRECHARGE at edge p
   function automatic logic [20:0] model(input int which,
                                         input int k,
                                         input int p);
      int trp, trfc, tmrd, n, rel;
      logic [3:0]  c;
      logic [12:0] a;
      logic        d;
      trp  = (which == 0) ? TRP0 : TRP1;
      trfc = (which == 0) ? TRFC0 : TRFC1;
      tmrd = (which == 0) ? TMRD0 : TMRD1;
      n    = (which == 0) ? N0 : N1;
      rel  = k - p;
      c = 4'b0111;
      a = '0;
      d = 1'b0;
      if (rel == 0) begin
         c = 4'b0010;
         a = 13'h0400;
      end else if (rel >= trp && rel < trp + n * trfc &&
                   (rel - trp) % trfc == 0) begin
         c = 4'b0001;
      end else if (rel == trp + n * trfc) begin
         c = 4'b0000;
         a = MODE;
      end else if (rel >= trp + n * trfc + tmrd) begin
         d = 1'b1;
      end
      return {1'b1, d, 2'b00, a, c};
   endfunction

   function automatic logic [20:0] observe(input int which);
      if (which == 0)
         return {cke0, done0, ba0, addr0, cmd0};
      return {cke1, done1, ba1, addr1, cmd1};
   endfunction

   task automatic check_rst(input int which, input string tag);
      logic [20:0] o;
      o = observe(which);
      check($sformatf("%s_cmd%0d", tag, which), 32'(o[3:0]), 32'hF);
      check($sformatf("%s_bus%0d", tag, which), 32'(o[20:4]), 32'h0);
   endtask

   task automatic set_reinit(input int which, input logic v);
      if (which == 0) reinit0 = v;
      else            reinit1 = v;
   endtask

   // Step edges from..to; random i_reinit noise on edges (from, upto]
   task automatic run_edges(input int which, input int from,
                            input int to, input int p,
                            input int upto);
      logic [20:0] m, o;
      for (int j = from; j <= to; j++) begin
         if (j > from && j <= upto)
            set_reinit(which, ($urandom_range(0, 3) == 0));
         else
            set_reinit(which, 1'b0);
         @(posedge clk);
         @(negedge clk);
         m = model(which, j, p);
         o = observe(which);
         check($sformatf("cmd%0d@%0d", which, j),
               32'(o[3:0]), 32'(m[3:0]));
         check($sformatf("bus%0d@%0d", which, j),
               32'(o[20:4]), 32'(m[20:4]));
      end
      set_reinit(which, 1'b0);
   endtask

`ifdef SDRAM_INIT_REINIT_EN
   task automatic do_reinit(input int which);
      logic [20:0] o;
      set_reinit(which, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_reinit(which, 1'b0);
      o = observe(which);
      check($sformatf("reinit_edge_cmd%0d", which),
            32'(o[3:0]), 32'h7);
      check($sformatf("reinit_edge_done%0d", which),
            32'(o[19]), 32'h1);
   endtask
`endif

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      reinit0 = 1'b0;
      reinit1 = 1'b0;
      repeat (3) @(negedge clk);
      check_rst(0, "reset");
      check_rst(1, "reset");

      rst0 = 1'b0;
      run_edges(0, 1, W0 + 1 + TRP0 + 3 * TRFC0, W0 + 1, D0);
      check("ref3_seen", 32'(cmd0), 32'h1);
      #2 rst0 = 1'b1;
      #1 check_rst(0, "async_rst");
      repeat ($urandom_range(1, 4)) @(negedge clk);
      check_rst(0, "held_rst");
      rst0 = 1'b0;
      run_edges(0, 1, D0 + 1000, W0 + 1, D0);

`ifdef SDRAM_INIT_REINIT_EN
      do_reinit(0);
      run_edges(0, 1, R0 + 200, 1, R0);
`endif

      rst1 = 1'b0;
      run_edges(1, 1, D1 + 50, W1 + 1, D1);

`ifdef SDRAM_INIT_REINIT_EN
      do_reinit(1);
      run_edges(1, 1, R1 + 20, 1, R1);
`endif

      #1 rst1 = 1'b1;
      #1 check_rst(1, "async_rst_done");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_init_ctrl.md
# sdram_init_ctrl

Power-up initialisation sequencer for the 32M×16 SDRAM. After reset release it holds the device idle for the power-up wait, then issues PRECHARGE ALL, a programmable number of AUTO REFRESH commands and LOAD MODE REGISTER, each followed by its required NOP gap. It then raises `o_init_done`, and the read/write/refresh controller takes over the command bus. It sits between the board reset generator and the SDRAM command multiplexer.

## Interface
- `P_WAIT_CYCLES`, 20000 — power-up wait in `s_clk` cycles (200 µs at 100 MHz); must be ≥1.
- `P_TRP`, 2 — cycles from PRECHARGE to the next command; must be ≥1.
- `P_TRFC`, 7 — cycles from AUTO REFRESH to the next command; must be ≥1.
- `P_TMRD`, 2 — cycles from LOAD MODE to `o_init_done`; must be ≥1.
- `P_REFRESH_NUM`, 8 — number of AUTO REFRESH commands, 1..15.
- `P_MODE_REG`, 13'h032 — mode word driven on `o_addr`: CL=3, sequential, BL=4.
- `s_clk` in 1 — system clock.
- `s_rst` in 1 — asynchronous, active-high reset.
- `o_cke` out 1 — SDRAM clock enable.
- `o_cmd` out 4 — {cs_n, ras_n, cas_n, we_n}.
- `o_addr` out 13 — SDRAM address bus.
- `o_ba` out 2 — bank address.
- `o_init_done` out 1 — level; high once the sequence has completed.
- `i_reinit` in 1 — present only with `SDRAM_INIT_REINIT_EN`.

## Operation
- Command encodings:
  - INHIBIT 1111
  - NOP 0111
  - PRECHARGE 0010
  - AUTO REFRESH 0001
  - LOAD MODE 0000
- All outputs are registered.
- FSM states and transitions:
  - WAIT → PRE
  - PRE → TRP
  - TRP → REF
  - REF → TRFC
  - TRFC → REF while refreshes remain, otherwise → LMR
  - LMR → TMRD
  - TMRD → DONE
- Timer: a single down-counter, loaded on each state entry with that state's gap minus 1.
- Refresh counter: 4-bit, incremented on each REF, compared against `P_REFRESH_NUM`.
- Command cycles:
  - PRE drives `o_addr[10]`=1 (all banks); all other `o_addr` bits are 0.
  - LMR drives `o_addr`=`P_MODE_REG` and `o_ba`=0.
- Gap and idle cycles drive NOP with `o_addr`=0 and `o_ba`=0.
- DONE drives NOP and holds `o_init_done`=1. DONE is terminal unless reinit is compiled in.
- Reset values: `o_cke`=0, `o_cmd`=INHIBIT, `o_addr`=0, `o_ba`=0, `o_init_done`=0, state=WAIT, counters=0.

## Timing
- Edge k means the kth rising edge after `s_rst` falls. W=`P_WAIT_CYCLES`, N=`P_REFRESH_NUM`.
- Power-up wait: `o_cke`=1 and NOP from edge 1 through edge W.
- PRECHARGE at edge W+1.
- AUTO REFRESH i (i = 0..N-1) at edge W+1+P_TRP+i·P_TRFC.
- LOAD MODE at edge W+1+P_TRP+N·P_TRFC.
- `o_init_done` rises at the LOAD MODE edge + P_TMRD.
- Each command is exactly one cycle wide; it is never repeated and never stretched.
- With defaults:
  - PRECHARGE at 20001
  - refreshes at 20003, 20010, …, 20052
  - LOAD MODE at 20059
  - done at 20061
- Reset asserted mid-sequence, including in DONE: all outputs return to their reset values asynchronously. The full sequence restarts from WAIT after release.
- Once `o_cke` is high it stays high until reset.

## Configuration
- `SDRAM_INIT_REINIT_EN` defined: adds the `i_reinit` port, which is sampled only in DONE and ignored in every other state.
- A high `i_reinit` at edge e in DONE:
  - clears `o_init_done` at edge e+1 and drives PRECHARGE at edge e+1;
  - runs PRE → TRP → REF… → DONE with the same gaps;
  - skips WAIT; `o_cke` stays 1.
- Not defined: the port is absent and DONE is terminal.

## Structure
- Package `sdram_pkg` holds:
  - command encoding localparams (`CMD_INHIBIT`, `CMD_NOP`, `CMD_PRE`, `CMD_REF`, `CMD_LMR`);
  - the FSM state enum;
  - mode-register field constants (CL, BT, BL).
- One sub-module, `sdram_init_timer`:
  - loadable down-counter with a zero flag;
  - width = clog2 of the largest of W, P_TRP, P_TRFC, P_TMRD, plus 1.

## Test plan
- Defaults: release reset at t0, then check:
  - NOP with `o_cke`=1 on edges 1–20000;
  - PRECHARGE with `o_addr`=0x400 on edge 20001;
  - REF on edges 20003 + 7i for i = 0..7;
  - LMR with `o_addr`=0x032 on edge 20059;
  - `o_init_done`=1 on edge 20061.
- During reset: `o_cmd`=1111, `o_cke`=0, `o_init_done`=0.
- Reset during REF #3: outputs return to their reset values immediately. After release, PRECHARGE occurs again W+1 edges later.
- Overrides W=4, P_REFRESH_NUM=1, all gaps=1:
  - PRECHARGE at edge 5, REF at 6, LMR at 7;
  - done at 8;
  - no NOP between commands.
- Reinit (macro defined): in DONE, pulse `i_reinit` one cycle at edge e. Check:
  - `o_init_done`=0 and PRECHARGE at e+1;
  - done again at e+1+2+56+2;
  - `i_reinit` pulses during the sequence are ignored.
- After done, hold for 1000 cycles: `o_cmd` stays NOP and `o_init_done` stays 1.
